// File: rtl/setup_hold_latch_monitor.sv
`default_nettype none
// =============================================================================
// setup_hold_latch_monitor : clocked WIDTH-bit D-latch with setup/hold checker
// Rev 1.0 - initial release
// =============================================================================
module setup_hold_latch_monitor #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 3,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] d,
   input  logic             g,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             setup_viol,
   output logic             hold_viol,
   output logic             q_ok,
   output logic [CNT_W-1:0] viol_cnt
);

   localparam int SC_W = $clog2(SETUP_CYC + 1);
   localparam int HC_W = $clog2(HOLD_CYC + 1);

   localparam logic [SC_W-1:0] c_setup_sat = SC_W'(SETUP_CYC);
   localparam logic [HC_W-1:0] c_hold_load = HC_W'(HOLD_CYC);
   localparam logic [HC_W-1:0] c_hold_last = HC_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_transp = 2'd1;
   localparam logic [1:0] c_hold   = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d_prev;
   logic             r_g_prev;
   logic [SC_W-1:0]  r_since_chg;
   logic [HC_W-1:0]  r_hold_cnt;
   logic [HC_W-1:0]  w_hold_cnt_nxt;
   logic             r_viol_seen;
   logic             w_viol_seen_nxt;
   logic             r_q_ok;
   logic             w_q_ok_nxt;
   logic             r_setup_viol;
   logic             r_hold_viol;
   logic [CNT_W-1:0] r_viol_cnt;

   logic             w_change;
   logic             w_fall;
   logic             w_setup_win;
   logic             w_setup_hit;
   logic             w_hold_hit;
   logic [1:0]       w_inc;
   logic [CNT_W:0]   w_sum;

   assign w_change    = (d != r_d_prev);
   assign w_fall      = r_g_prev & ~g;
   // A change within the last SETUP_CYC edges leaves the counter below saturation.
   assign w_setup_win = (r_since_chg < c_setup_sat);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:   if (g) w_state_nxt = c_transp;
         c_transp: if (w_fall) w_state_nxt = c_hold;
         c_hold: begin
            if (g)                              w_state_nxt = c_transp;
            else if (r_hold_cnt == c_hold_last) w_state_nxt = c_idle;
         end
         default:  w_state_nxt = c_idle;
      endcase
   end

   always_comb begin
      w_setup_hit     = 1'b0;
      w_hold_hit      = 1'b0;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_viol_seen_nxt = r_viol_seen;
      w_q_ok_nxt      = r_q_ok;
      case (r_state)
         c_idle: begin
            if (g) w_q_ok_nxt = 1'b0;
         end
         c_transp: begin
            if (w_fall) begin
               w_setup_hit     = w_setup_win;
               w_hold_hit      = w_change;
               w_hold_cnt_nxt  = c_hold_load;
               w_viol_seen_nxt = w_setup_win | w_change;
            end
         end
         c_hold: begin
            // Re-opening the latch abandons the window for this capture.
            if (g) begin
               w_q_ok_nxt = 1'b0;
            end else if (r_hold_cnt == c_hold_last) begin
               w_q_ok_nxt = ~r_viol_seen;
            end else begin
               w_hold_hit      = w_change;
               w_hold_cnt_nxt  = r_hold_cnt - c_hold_last;
               w_viol_seen_nxt = r_viol_seen | w_change;
            end
         end
         default: ;
      endcase
   end

   assign w_inc = {1'b0, w_setup_hit} + {1'b0, w_hold_hit};
   assign w_sum = {1'b0, r_viol_cnt} + (CNT_W+1)'(w_inc);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_q          <= '0;
         r_d_prev     <= '0;
         r_g_prev     <= 1'b0;
         r_since_chg  <= c_setup_sat;
         r_hold_cnt   <= '0;
         r_viol_seen  <= 1'b0;
         r_q_ok       <= 1'b0;
         r_setup_viol <= 1'b0;
         r_hold_viol  <= 1'b0;
         r_viol_cnt   <= '0;
      end else begin
         if (g) r_q <= d;
         r_d_prev     <= d;
         r_g_prev     <= g;
         if (w_change)                       r_since_chg <= '0;
         else if (r_since_chg < c_setup_sat) r_since_chg <= r_since_chg + 1'b1;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_viol_seen  <= w_viol_seen_nxt;
         r_q_ok       <= w_q_ok_nxt;
         r_setup_viol <= w_setup_hit;
         r_hold_viol  <= w_hold_hit;
         if (clr_cnt)         r_viol_cnt <= '0;
         else if (w_sum[CNT_W]) r_viol_cnt <= c_cnt_max;
         else                 r_viol_cnt <= w_sum[CNT_W-1:0];
      end
   end

   assign q          = r_q;
   assign qb         = ~r_q;
   assign setup_viol = r_setup_viol;
   assign hold_viol  = r_hold_viol;
   assign q_ok       = r_q_ok;
   assign viol_cnt   = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_setup_hold_latch_monitor.sv
`default_nettype none
// =============================================================================
// tb_setup_hold_latch_monitor : directed bench for setup_hold_latch_monitor
// Rev 1.0 - initial release
// =============================================================================
module tb_setup_hold_latch_monitor;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [7:0] d;
   logic       g;
   logic       clr_cnt;

   logic [7:0]  q, qb, q_s, qb_s;
   logic        setup_viol, hold_viol, q_ok;
   logic        setup_viol_s, hold_viol_s, q_ok_s;
   logic [15:0] viol_cnt;
   logic [1:0]  viol_cnt_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   setup_hold_latch_monitor dut (
      .clk(clk), .reset_L(reset_L), .d(d), .g(g), .clr_cnt(clr_cnt),
      .q(q), .qb(qb), .setup_viol(setup_viol), .hold_viol(hold_viol),
      .q_ok(q_ok), .viol_cnt(viol_cnt)
   );

   setup_hold_latch_monitor #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset_L(reset_L), .d(d), .g(g), .clr_cnt(clr_cnt),
      .q(q_s), .qb(qb_s), .setup_viol(setup_viol_s), .hold_viol(hold_viol_s),
      .q_ok(q_ok_s), .viol_cnt(viol_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [7:0] dv, input logic gv, input logic cv);
      d       = dv;
      g       = gv;
      clr_cnt = cv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_L = 1'b0;
      d       = 8'h00;
      g       = 1'b0;
      clr_cnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q",    32'(q),          32'h00);
      check("rst_qb",   32'(qb),         32'hFF);
      check("rst_qok",  32'(q_ok),       32'h0);
      check("rst_cnt",  32'(viol_cnt),   32'h0);
      reset_L = 1'b1;

      // clean capture
      repeat (4) tick(8'h3C, 1'b0, 1'b0);
      repeat (4) tick(8'h3C, 1'b1, 1'b0);
      tick(8'h3C, 1'b0, 1'b0);
      check("clean_sv",   32'(setup_viol), 32'h0);
      check("clean_hv",   32'(hold_viol),  32'h0);
      check("clean_q",    32'(q),          32'h3C);
      tick(8'h3C, 1'b0, 1'b0);
      check("clean_qok1", 32'(q_ok),       32'h0);
      tick(8'h3C, 1'b0, 1'b0);
      check("clean_qok2", 32'(q_ok),       32'h1);
      check("clean_cnt",  32'(viol_cnt),   32'h0);
      check("clean_qb",   32'(qb),         32'hC3);

      // setup violation: change one edge before the fall
      repeat (4) tick(8'h00, 1'b1, 1'b0);
      check("su_q0",   32'(q),          32'h00);
      check("su_qok0", 32'(q_ok),       32'h0);
      tick(8'h11, 1'b1, 1'b0);
      tick(8'h11, 1'b0, 1'b0);
      check("su_sv",   32'(setup_viol), 32'h1);
      check("su_hv",   32'(hold_viol),  32'h0);
      check("su_q",    32'(q),          32'h11);
      check("su_cnt",  32'(viol_cnt),   32'h1);
      tick(8'h11, 1'b0, 1'b0);
      check("su_sv_off", 32'(setup_viol), 32'h0);
      tick(8'h11, 1'b0, 1'b0);
      check("su_qok",  32'(q_ok),       32'h0);
      check("su_cnt2", 32'(viol_cnt),   32'h1);

      // hold violation: changes at the fall edge and one edge later
      tick(8'h11, 1'b0, 1'b1);
      check("clr_cnt", 32'(viol_cnt), 32'h0);
      repeat (3) tick(8'h11, 1'b1, 1'b0);
      tick(8'h22, 1'b0, 1'b0);
      check("ho_hv1",  32'(hold_viol),  32'h1);
      check("ho_sv",   32'(setup_viol), 32'h0);
      check("ho_q1",   32'(q),          32'h11);
      check("ho_cnt1", 32'(viol_cnt),   32'h1);
      tick(8'h33, 1'b0, 1'b0);
      check("ho_hv2",  32'(hold_viol),  32'h1);
      check("ho_cnt2", 32'(viol_cnt),   32'h2);
      check("ho_q2",   32'(q),          32'h11);
      check("ho_qb",   32'(qb),         32'hEE);
      tick(8'h33, 1'b0, 1'b0);
      check("ho_hv_off", 32'(hold_viol), 32'h0);
      check("ho_qok",  32'(q_ok),       32'h0);

      // early re-open of the latch during the hold window
      repeat (4) tick(8'h44, 1'b1, 1'b0);
      tick(8'h44, 1'b0, 1'b0);
      check("ro_sv",   32'(setup_viol), 32'h0);
      tick(8'h55, 1'b1, 1'b0);
      check("ro_hv",   32'(hold_viol),  32'h0);
      check("ro_q",    32'(q),          32'h55);
      check("ro_qok",  32'(q_ok),       32'h0);
      check("ro_cnt",  32'(viol_cnt),   32'h2);
      repeat (3) tick(8'h55, 1'b1, 1'b0);
      repeat (3) tick(8'h55, 1'b0, 1'b0);
      check("ro_qok2", 32'(q_ok),       32'h1);
      check("ro_cnt2", 32'(viol_cnt),   32'h2);

      // saturation on the 2-bit counter, then clear vs. increment
      tick(8'h55, 1'b0, 1'b1);
      check("sat_clr",  32'(viol_cnt_s), 32'h0);
      tick(8'h55, 1'b1, 1'b0);
      tick(8'h66, 1'b1, 1'b0);
      tick(8'h77, 1'b0, 1'b0);
      check("both_sv",  32'(setup_viol), 32'h1);
      check("both_hv",  32'(hold_viol),  32'h1);
      check("both_cnt", 32'(viol_cnt),   32'h2);
      tick(8'h88, 1'b0, 1'b0);
      check("sat_cnt3", 32'(viol_cnt_s), 32'h3);
      tick(8'h88, 1'b0, 1'b0);
      tick(8'h99, 1'b1, 1'b0);
      tick(8'hAA, 1'b0, 1'b0);
      check("sat_hold", 32'(viol_cnt_s), 32'h3);
      check("wide_cnt", 32'(viol_cnt),   32'h5);
      repeat (2) tick(8'hAA, 1'b0, 1'b0);
      tick(8'hBB, 1'b1, 1'b0);
      tick(8'hBB, 1'b0, 1'b1);
      check("clrpri_sv",  32'(setup_viol_s), 32'h1);
      check("clrpri_cnt", 32'(viol_cnt_s),   32'h0);
      check("clrpri_w",   32'(viol_cnt),     32'h0);
      repeat (2) tick(8'hBB, 1'b0, 1'b0);

      // asynchronous reset in the middle of a hold window
      tick(8'hA5, 1'b1, 1'b0);
      tick(8'h5A, 1'b0, 1'b0);
      tick(8'hA5, 1'b0, 1'b0);
      check("pre_q",   32'(q),         32'hA5);
      check("pre_cnt", 32'(viol_cnt),  32'h3);
      check("pre_hv",  32'(hold_viol), 32'h1);
      #2 reset_L = 1'b0;
      #1;
      check("arst_q",   32'(q),          32'h00);
      check("arst_qb",  32'(qb),         32'hFF);
      check("arst_sv",  32'(setup_viol), 32'h0);
      check("arst_hv",  32'(hold_viol),  32'h0);
      check("arst_qok", 32'(q_ok),       32'h0);
      check("arst_cnt", 32'(viol_cnt),   32'h0);
      check("arst_cnts", 32'(viol_cnt_s), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
